// File: rtl/life_sequencer.sv
// Game-of-Life sequencer: turns start/pause/clear commands into load/step/clear engine handshakes.
// Latency: command edge to req one clock; req drops the clock after its done is sampled.
// Backpressure: each engine stalls the sequencer by withholding done; handshakes are never aborted.
//
// Ports:
//   clk_in, reset             clock and asynchronous active-high reset
//   start, pause, clear       command levels from the keyboard block (edge-detected here)
//   file_id                   pattern index, sampled on a start edge in IDLE
//   load_req/load_id/load_done   pattern loader handshake
//   step_req/step_done           generation stepper handshake
//   clr_req/clr_done             memory clearer handshake
//   running                   high in RUN or STEP
//   generation                generations completed since the last load or clear
module life_sequencer #(
  parameter int TICK_DIV = 10_000_000,
  parameter int GEN_W    = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [15:0]      file_id,
  output logic             load_req,
  output logic [15:0]      load_id,
  input  logic             load_done,
  output logic             step_req,
  input  logic             step_done,
  output logic             clr_req,
  input  logic             clr_done,
  output logic             running,
  output logic [GEN_W-1:0] generation
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_STEP = 3'd3;
  localparam logic [2:0] ST_CLR  = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] tick_cnt;
  logic             loaded_valid;
  logic [15:0]      loaded_id;
  logic             pending_clear;
  logic             pending_pause;
  logic             start_q;
  logic             pause_q;
  logic             clear_q;

  logic start_edge;
  logic pause_edge;
  logic clear_edge;
  logic clear_seen;
  logic pause_seen;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign clear_edge = clear & ~clear_q;

  // An edge landing in the same cycle as a done still counts toward the exit decision.
  assign clear_seen = pending_clear | clear_edge;
  assign pause_seen = pending_pause | pause_edge;

  assign running = (state == ST_RUN) || (state == ST_STEP);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      loaded_valid  <= 1'b0;
      loaded_id     <= '0;
      pending_clear <= 1'b0;
      pending_pause <= 1'b0;
      start_q       <= 1'b0;
      pause_q       <= 1'b0;
      clear_q       <= 1'b0;
      load_req      <= 1'b0;
      load_id       <= '0;
      step_req      <= 1'b0;
      clr_req       <= 1'b0;
      generation    <= '0;
    end else begin
      start_q <= start;
      pause_q <= pause;
      clear_q <= clear;

      case (state)
        ST_IDLE: begin
          if (clear_edge) begin
            state   <= ST_CLR;
            clr_req <= 1'b1;
          end else if (start_edge) begin
            if (!loaded_valid || (file_id != loaded_id)) begin
              state    <= ST_LOAD;
              load_req <= 1'b1;
              load_id  <= file_id;
            end else begin
              // Same pattern already in memory: resume with the held tick count.
              state <= ST_RUN;
            end
          end
        end

        ST_LOAD: begin
          if (load_done) begin
            load_req      <= 1'b0;
            loaded_id     <= load_id;
            loaded_valid  <= 1'b1;
            generation    <= '0;
            tick_cnt      <= '0;
            pending_clear <= 1'b0;
            pending_pause <= 1'b0;
            if (clear_seen) begin
              state   <= ST_CLR;
              clr_req <= 1'b1;
            end else if (pause_seen) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            pending_clear <= clear_seen;
            pending_pause <= pause_seen;
          end
        end

        ST_RUN: begin
          if (clear_edge) begin
            state   <= ST_CLR;
            clr_req <= 1'b1;
          end else if (pause_edge) begin
            state <= ST_IDLE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            state    <= ST_STEP;
            step_req <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        ST_STEP: begin
          if (step_done) begin
            step_req      <= 1'b0;
            generation    <= generation + 1'b1;
            pending_clear <= 1'b0;
            pending_pause <= 1'b0;
            if (clear_seen) begin
              state   <= ST_CLR;
              clr_req <= 1'b1;
            end else if (pause_seen) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            pending_clear <= clear_seen;
            pending_pause <= pause_seen;
          end
        end

        ST_CLR: begin
          if (clr_done) begin
            clr_req      <= 1'b0;
            generation   <= '0;
            loaded_valid <= 1'b0;
            tick_cnt     <= '0;
            state        <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          load_req <= 1'b0;
          step_req <= 1'b0;
          clr_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: directed scenarios followed by randomized commands and engine timing.
// Outputs are compared against a behavioural model every cycle outside reset.
// Engines are emulated with programmable done delays and optional spurious strobes.
module tb_life_sequencer;

  localparam int TD = 4;
  localparam int GW = 4;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          clear = 1'b0;
  logic [15:0]   file_id = 16'd0;
  logic          load_req;
  logic [15:0]   load_id;
  logic          load_done = 1'b0;
  logic          step_req;
  logic          step_done = 1'b0;
  logic          clr_req;
  logic          clr_done = 1'b0;
  logic          running;
  logic [GW-1:0] generation;

  int checks = 0;
  int errors = 0;

  life_sequencer #(.TICK_DIV(TD), .GEN_W(GW)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .file_id(file_id), .load_req(load_req), .load_id(load_id), .load_done(load_done),
    .step_req(step_req), .step_done(step_done), .clr_req(clr_req), .clr_done(clr_done),
    .running(running), .generation(generation)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 running, 3 stepping, 4 clearing
  int          m_mode;
  logic [15:0] m_load_id;
  logic [15:0] m_have_id;
  bit          m_have;
  bit          m_want_clear, m_want_pause;
  int          m_tick;
  int          m_gen;
  bit          h_start, h_pause, h_clear;

  always @(posedge clk_in or posedge reset) begin : model
    bit ce, pe, se, leave;
    if (reset) begin
      m_mode = 0; m_load_id = 0; m_have_id = 0; m_have = 0;
      m_want_clear = 0; m_want_pause = 0; m_tick = 0; m_gen = 0;
      h_start = 0; h_pause = 0; h_clear = 0;
    end else begin
      ce = clear && !h_clear;
      pe = pause && !h_pause;
      se = start && !h_start;
      h_start = start; h_pause = pause; h_clear = clear;
      leave = 0;
      if (m_mode == 0) begin
        if (ce) m_mode = 4;
        else if (se) begin
          if (!m_have || file_id != m_have_id) begin m_mode = 1; m_load_id = file_id; end
          else m_mode = 2;
        end
      end else if (m_mode == 1 || m_mode == 3) begin
        m_want_clear = m_want_clear || ce;
        m_want_pause = m_want_pause || pe;
        if (m_mode == 1 && load_done) begin
          m_have_id = m_load_id; m_have = 1; m_gen = 0; m_tick = 0; leave = 1;
        end
        if (m_mode == 3 && step_done) begin
          m_gen = (m_gen + 1) % (1 << GW); leave = 1;
        end
        if (leave) begin
          m_mode = m_want_clear ? 4 : (m_want_pause ? 0 : 2);
          m_want_clear = 0; m_want_pause = 0;
        end
      end else if (m_mode == 2) begin
        if (ce) m_mode = 4;
        else if (pe) m_mode = 0;
        else if (m_tick == TD - 1) begin m_tick = 0; m_mode = 3; end
        else m_tick++;
      end else if (m_mode == 4) begin
        if (clr_done) begin m_gen = 0; m_have = 0; m_tick = 0; m_mode = 0; end
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk_in) begin
    if (!reset && cmp_en) begin
      chk("load_req", {31'd0, load_req}, {31'd0, m_mode == 1});
      chk("step_req", {31'd0, step_req}, {31'd0, m_mode == 3});
      chk("clr_req", {31'd0, clr_req}, {31'd0, m_mode == 4});
      chk("running", {31'd0, running}, {31'd0, m_mode == 2 || m_mode == 3});
      chk("generation", 32'(generation), 32'(m_gen));
      if (m_mode == 1) chk("load_id", {16'd0, load_id}, {16'd0, m_load_id});
    end
  end

  // ---------------- engine emulation ----------------
  int ld_cnt = -1, st_cnt = -1, cl_cnt = -1;
  int ld_dly = 5, st_dly = 2, cl_dly = 2;
  bit rnd_dly = 0, spur_en = 0, inj_step = 0;

  task automatic eng(input bit req, input int dly, inout int cnt, output logic done);
    done = 1'b0;
    if (!req) begin
      cnt = -1;
      if (spur_en && ($urandom % 25 == 0)) done = 1'b1;
    end else begin
      if (cnt == -1) cnt = rnd_dly ? int'($urandom % 5) : dly;
      if (cnt == 0) begin done = 1'b1; cnt = -2; end
      else if (cnt > 0) cnt--;
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
    eng(m_mode == 1, ld_dly, ld_cnt, load_done);
    eng(m_mode == 3, st_dly, st_cnt, step_done);
    eng(m_mode == 4, cl_dly, cl_cnt, clr_done);
    if (inj_step) step_done = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r1, r2, rises, exp_gen;
    bit prevq;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("reset_load_req", {31'd0, load_req}, 32'd0);
    chk("reset_running", {31'd0, running}, 32'd0);
    chk("reset_generation", 32'(generation), 32'd0);
    chk("reset_load_id", {16'd0, load_id}, 32'd0);
    reset = 1'b0;
    cmp_en = 1;

    // First load of pattern 3
    file_id = 16'd3; start = 1'b1;
    cyc(); start = 1'b0;
    chk("first_load_req", {31'd0, load_req}, 32'd1);
    chk("first_load_id", {16'd0, load_id}, 32'd3);
    for (int i = 0; i < 20 && !running; i++) cyc();
    chk("run_after_load", {31'd0, running}, 32'd1);
    chk("gen_after_load", 32'(generation), 32'd0);

    // Step pacing: 4 RUN cycles + 3 STEP cycles per generation
    r1 = -1; r2 = -1; prevq = step_req;
    for (int i = 0; i < 40 && r2 < 0; i++) begin
      cyc();
      if (step_req && !prevq) begin if (r1 < 0) r1 = i; else r2 = i; end
      prevq = step_req;
    end
    chk("step_period", 32'(r2 - r1), 32'd7);
    for (int i = 0; i < 50 && generation !== 3; i++) cyc();
    chk("gen_reaches_3", 32'(generation), 32'd3);
    for (int i = 0; i < 200 && generation !== 15; i++) cyc();
    chk("gen_reaches_max", 32'(generation), 32'd15);
    for (int i = 0; i < 20 && generation === 15; i++) cyc();
    chk("gen_wraps", 32'(generation), 32'd0);

    // Pause during STEP
    for (int i = 0; i < 20 && !step_req; i++) cyc();
    exp_gen = (m_gen + 1) % (1 << GW);
    pause = 1'b1; cyc(); pause = 1'b0;
    chk("pause_holds_step", {31'd0, step_req}, 32'd1);
    for (int i = 0; i < 20 && running; i++) cyc();
    chk("pause_idle", {31'd0, running}, 32'd0);
    chk("pause_gen_inc", 32'(generation), 32'(exp_gen));
    start = 1'b1; cyc(); start = 1'b0;
    chk("resume_running", {31'd0, running}, 32'd1);
    chk("resume_no_load", {31'd0, load_req}, 32'd0);

    // New pattern while paused
    cyc(); pause = 1'b1; cyc(); pause = 1'b0;
    for (int i = 0; i < 20 && running; i++) cyc();
    file_id = 16'd5; start = 1'b1; cyc(); start = 1'b0;
    chk("reload_req", {31'd0, load_req}, 32'd1);
    chk("reload_id", {16'd0, load_id}, 32'd5);
    for (int i = 0; i < 20 && !running; i++) cyc();
    chk("reload_gen0", 32'(generation), 32'd0);

    // Clear and start together in RUN
    for (int i = 0; i < 20 && !(running && !step_req); i++) cyc();
    clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
    chk("clear_wins_req", {31'd0, clr_req}, 32'd1);
    chk("clear_wins_noload", {31'd0, load_req}, 32'd0);
    for (int i = 0; i < 20 && clr_req; i++) cyc();
    chk("clear_gen0", 32'(generation), 32'd0);
    chk("clear_idle", {31'd0, running}, 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("load_after_clear", {31'd0, load_req}, 32'd1);

    // Held start level triggers exactly one load
    for (int i = 0; i < 20 && !running; i++) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    for (int i = 0; i < 20 && running; i++) cyc();
    file_id = 16'd9; start = 1'b1; rises = 0; prevq = load_req;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (load_req && !prevq) rises++;
      prevq = load_req;
    end
    start = 1'b0;
    chk("held_start_one_load", 32'(rises), 32'd1);

    // Spurious step_done in IDLE
    pause = 1'b1; cyc(); pause = 1'b0;
    for (int i = 0; i < 20 && running; i++) cyc();
    exp_gen = m_gen;
    inj_step = 1; cyc(); inj_step = 0; cyc(); cyc();
    chk("spurious_running", {31'd0, running}, 32'd0);
    chk("spurious_gen", 32'(generation), 32'(exp_gen));

    // Reset in the middle of a load handshake
    ld_dly = 10; file_id = 16'd11; start = 1'b1; cyc(); start = 1'b0;
    chk("pre_reset_load_req", {31'd0, load_req}, 32'd1);
    cyc();
    #2 reset = 1'b1;
    #1 chk("async_reset_load_req", {31'd0, load_req}, 32'd0);
    @(negedge clk_in);
    reset = 1'b0;
    ld_cnt = -1; st_cnt = -1; cl_cnt = -1;
    load_done = 1'b0; step_done = 1'b0; clr_done = 1'b0;

    // Randomized phase
    rnd_dly = 1; spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      start = ($urandom % 6 == 0);
      pause = ($urandom % 12 == 0);
      clear = ($urandom % 40 == 0);
      if ($urandom % 50 == 0) file_id = 16'($urandom % 3 + 1);
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    cyc(); cyc();
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
